text_buffer_ctrl: RTL and testbench

Write-side controller for the LCD character buffer. It accepts key events from the keyboard decoder over a valid/ready handshake and maintains a cursor over the 2×16 display. It sequences all writes into the character memory that the LCD block reads from: typed characters, backspace blanking, and full-screen clears. It drives the memory's `wr_addr`/`wr_en`/`wr_data` port; the LCD read path is untouched.

---
 rtl/text_buffer_ctrl.sv | 165 ++++++++++++++++
 tb/tb_text_buffer_ctrl.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/text_buffer_ctrl.sv
// text_buffer_ctrl: write-side sequencer for the 2x16 LCD character memory.
// Accepts key events over valid/ready, keeps the cursor, and issues
// character, backspace-blank and full-screen clear writes. Every output
// is a register, so wr_addr/wr_data are stable for the whole wr_en cycle.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// ST_IDLE  | ready for a key event (key_ready=1, busy=0)
// ST_WRITE | one-cycle write/turnaround after an accepted edit key
// ST_CLEAR | blanking cells 0..CELLS-1, one per cycle; also the reset state
module text_buffer_ctrl #(
    parameter int               DATA_W = 9,
    parameter int               ADDR_W = 6,
    parameter int               COLS   = 16,
    parameter int               ROWS   = 2,
    parameter logic [DATA_W-1:0] BLANK = 9'h020
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              key_valid,
    output logic              key_ready,
    input  logic [1:0]        key_cmd,
    input  logic [DATA_W-1:0] key_code,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic [ADDR_W-1:0] cursor,
    output logic              busy
);

    localparam int CELLS = ROWS * COLS;
    // One extra bit so the clear counter can reach CELLS as its terminal count.
    localparam int CNT_W = ADDR_W + 1;

    localparam logic [1:0] CMD_CHAR  = 2'b00;
    localparam logic [1:0] CMD_BKSP  = 2'b01;
    localparam logic [1:0] CMD_NEWLN = 2'b10;
    localparam logic [1:0] CMD_CLEAR = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WRITE,
        ST_CLEAR
    } state_t;

    state_t             state, state_nxt;
    logic [CNT_W-1:0]   clr_cnt, clr_cnt_nxt;
    logic [ADDR_W-1:0]  cursor_nxt;
    logic               wr_en_nxt;
    logic [ADDR_W-1:0]  wr_addr_nxt;
    logic [DATA_W-1:0]  wr_data_nxt;
    logic               key_ready_nxt;
    logic               busy_nxt;
    logic [ADDR_W-1:0]  newline_pos;
    int                 row_next;

    // Register all state and outputs; reset parks in CLEAR so the screen is blanked on release.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_CLEAR;
            clr_cnt   <= '0;
            cursor    <= '0;
            wr_en     <= 1'b0;
            wr_addr   <= '0;
            wr_data   <= BLANK;
            key_ready <= 1'b0;
            busy      <= 1'b1;
        end else begin
            state     <= state_nxt;
            clr_cnt   <= clr_cnt_nxt;
            cursor    <= cursor_nxt;
            wr_en     <= wr_en_nxt;
            wr_addr   <= wr_addr_nxt;
            wr_data   <= wr_data_nxt;
            key_ready <= key_ready_nxt;
            busy      <= busy_nxt;
        end
    end

    // Start of the next row, wrapping from the last row back to cell 0.
    always_comb begin
        row_next    = (int'(cursor) / COLS + 1) * COLS;
        newline_pos = (row_next >= CELLS) ? '0 : ADDR_W'(row_next);
    end

    // Next-state and next-output decode.
    always_comb begin
        state_nxt     = state;
        clr_cnt_nxt   = clr_cnt;
        cursor_nxt    = cursor;
        wr_en_nxt     = 1'b0;
        wr_addr_nxt   = wr_addr;
        wr_data_nxt   = wr_data;
        key_ready_nxt = 1'b0;
        busy_nxt      = 1'b1;

        case (state)
            ST_IDLE: begin
                key_ready_nxt = 1'b1;
                busy_nxt      = 1'b0;
                if (key_valid && key_ready) begin
                    state_nxt     = ST_WRITE;
                    key_ready_nxt = 1'b0;
                    busy_nxt      = 1'b1;
                    case (key_cmd)
                        CMD_CHAR: begin
                            wr_en_nxt   = 1'b1;
                            wr_addr_nxt = cursor;
                            wr_data_nxt = key_code;
                            cursor_nxt  = (cursor == ADDR_W'(CELLS - 1)) ?
                                          '0 : cursor + ADDR_W'(1);
                        end
                        CMD_BKSP: begin
                            if (cursor != '0) begin
                                cursor_nxt  = cursor - ADDR_W'(1);
                                wr_en_nxt   = 1'b1;
                                wr_addr_nxt = cursor - ADDR_W'(1);
                                wr_data_nxt = BLANK;
                            end
                        end
                        CMD_NEWLN: begin
                            cursor_nxt = newline_pos;
                        end
                        CMD_CLEAR: begin
                            // Cell 0 is presented on the accepting edge itself.
                            state_nxt   = ST_CLEAR;
                            wr_en_nxt   = 1'b1;
                            wr_addr_nxt = '0;
                            wr_data_nxt = BLANK;
                            clr_cnt_nxt = CNT_W'(1);
                        end
                        default: ;
                    endcase
                end
            end

            ST_WRITE: begin
                state_nxt     = ST_IDLE;
                key_ready_nxt = 1'b1;
                busy_nxt      = 1'b0;
            end

            ST_CLEAR: begin
                if (clr_cnt < CNT_W'(CELLS)) begin
                    wr_en_nxt   = 1'b1;
                    wr_addr_nxt = clr_cnt[ADDR_W-1:0];
                    wr_data_nxt = BLANK;
                    clr_cnt_nxt = clr_cnt + CNT_W'(1);
                end else begin
                    state_nxt     = ST_IDLE;
                    clr_cnt_nxt   = '0;
                    cursor_nxt    = '0;
                    key_ready_nxt = 1'b1;
                    busy_nxt      = 1'b0;
                end
            end

            default: begin
                state_nxt   = ST_CLEAR;
                clr_cnt_nxt = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_text_buffer_ctrl.sv
// tb_text_buffer_ctrl: directed vectors for the LCD buffer write controller.
module tb_text_buffer_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       key_valid = 1'b0;
    logic       key_ready;
    logic [1:0] key_cmd = 2'b00;
    logic [8:0] key_code = 9'h000;
    logic       wr_en;
    logic [5:0] wr_addr;
    logic [8:0] wr_data;
    logic [5:0] cursor;
    logic       busy;

    int n_checks = 0;
    int n_err    = 0;
    int cyc      = 0;

    typedef struct {
        int cyc;
        int addr;
        int data;
    } wr_t;
    wr_t wlog[$];

    text_buffer_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .key_valid (key_valid),
        .key_ready (key_ready),
        .key_cmd   (key_cmd),
        .key_code  (key_code),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .cursor    (cursor),
        .busy      (busy)
    );

    // 10 ns clock.
    always #5 clk = ~clk;

    // Cycle index: value N seen after edge N.
    always @(posedge clk) cyc++;

    // Log every write at mid-cycle.
    always @(negedge clk) begin
        if (wr_en === 1'b1) wlog.push_back('{cyc, int'(wr_addr), int'(wr_data)});
    end

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready(input int max_cyc);
        int k = 0;
        while (key_ready !== 1'b1 && k < max_cyc) begin
            tick();
            k++;
        end
        check("ready_timeout", int'(key_ready), 1);
    endtask

    task automatic send(input logic [1:0] c, input logic [8:0] code);
        check("rdy_before_send", int'(key_ready), 1);
        key_cmd   = c;
        key_code  = code;
        key_valid = 1'b1;
        tick();
        key_valid = 1'b0;
    endtask

    // Expects 32 blanking writes at addresses 0..31 on consecutive cycles from base.
    task automatic check_clear(input int base);
        check("clr_count", (wlog.size() >= 32) ? 32 : wlog.size(), 32);
        for (int i = 0; i < 32 && i < wlog.size(); i++) begin
            check($sformatf("clr_addr[%0d]", i), wlog[i].addr, i);
            check($sformatf("clr_data[%0d]", i), wlog[i].data, 'h020);
            check($sformatf("clr_cyc[%0d]", i), wlog[i].cyc, base + i);
        end
    endtask

    initial begin
        int rel, n_clr, acc, k;

        // Reset values and post-reset clear.
        repeat (3) tick();
        check("rst_wr_en", int'(wr_en), 0);
        check("rst_wr_addr", int'(wr_addr), 0);
        check("rst_wr_data", int'(wr_data), 'h020);
        check("rst_ready", int'(key_ready), 0);
        check("rst_busy", int'(busy), 1);
        check("rst_cursor", int'(cursor), 0);
        rst = 1'b0;
        rel = cyc;
        wlog.delete();
        wait_ready(60);
        check_clear(rel + 1);
        check("rstclr_total", wlog.size(), 32);
        check("rstclr_cursor", int'(cursor), 0);
        check("rstclr_busy", int'(busy), 0);

        // Typing 'A','B'.
        wlog.delete();
        send(2'b00, 9'h041);
        acc = cyc;
        check("typeA_ready_low", int'(key_ready), 0);
        check("typeA_busy", int'(busy), 1);
        tick();
        check("typeA_ready_back", int'(key_ready), 1);
        check("typeA_wr_en_off", int'(wr_en), 0);
        send(2'b00, 9'h042);
        tick();
        check("type_nwrites", wlog.size(), 2);
        if (wlog.size() == 2) begin
            check("typeA_addr", wlog[0].addr, 0);
            check("typeA_data", wlog[0].data, 'h041);
            check("typeA_cyc", wlog[0].cyc, acc);
            check("typeB_addr", wlog[1].addr, 1);
            check("typeB_data", wlog[1].data, 'h042);
            check("typeB_cyc", wlog[1].cyc, acc + 2);
        end
        check("type_cursor", int'(cursor), 2);

        // Clear with a char held valid behind it.
        wlog.delete();
        send(2'b11, 9'h000);
        n_clr = cyc;
        check("clr_first_wr_en", int'(wr_en), 1);
        check("clr_first_addr", int'(wr_addr), 0);
        key_cmd   = 2'b00;
        key_code  = 9'h041;
        key_valid = 1'b1;
        acc = -1;
        k = 0;
        while (acc < 0 && k < 50) begin
            if (k == 10) check("clr_cursor_held", int'(cursor), 2);
            tick();
            k++;
            if (wr_en === 1'b1 && wr_data === 9'h041) begin
                acc = cyc;
                key_valid = 1'b0;
            end
        end
        key_valid = 1'b0;
        check("held_accept_cyc", acc, n_clr + 33);
        check("held_addr", int'(wr_addr), 0);
        check("held_cursor", int'(cursor), 1);
        tick();
        check_clear(n_clr);
        check("held_nwrites", wlog.size(), 33);
        if (wlog.size() == 33) begin
            check("held_log_addr", wlog[32].addr, 0);
            check("held_log_data", wlog[32].data, 'h041);
        end

        // Backspace at cursor 1, then at cursor 0.
        wlog.delete();
        send(2'b01, 9'h000);
        check("bs1_wr_en", int'(wr_en), 1);
        check("bs1_addr", int'(wr_addr), 0);
        check("bs1_data", int'(wr_data), 'h020);
        check("bs1_cursor", int'(cursor), 0);
        tick();
        send(2'b01, 9'h000);
        check("bs0_wr_en", int'(wr_en), 0);
        check("bs0_cursor", int'(cursor), 0);
        check("bs0_ready_low", int'(key_ready), 0);
        tick();
        check("bs0_ready_back", int'(key_ready), 1);
        check("bs_nwrites", wlog.size(), 1);

        // 32 chars from cell 0 wrap the cursor.
        wlog.delete();
        for (int i = 0; i < 32; i++) begin
            send(2'b00, 9'h041 + 9'(i));
            tick();
        end
        check("wrap_nwrites", wlog.size(), 32);
        if (wlog.size() == 32) begin
            check("wrap_first_addr", wlog[0].addr, 0);
            check("wrap_last_addr", wlog[31].addr, 31);
            check("wrap_last_data", wlog[31].data, 'h041 + 31);
        end
        check("wrap_cursor", int'(cursor), 0);

        // Newlines: 0 -> 16 -> 0, no writes.
        wlog.delete();
        send(2'b10, 9'h000);
        check("nl1_cursor", int'(cursor), 16);
        tick();
        send(2'b10, 9'h000);
        check("nl2_cursor", int'(cursor), 0);
        tick();
        check("nl_nwrites", wlog.size(), 0);

        // Backspace at cursor 5, then newline from mid-row.
        for (int i = 0; i < 5; i++) begin
            send(2'b00, 9'h030 + 9'(i));
            tick();
        end
        check("pre_bs5_cursor", int'(cursor), 5);
        send(2'b01, 9'h000);
        check("bs5_wr_en", int'(wr_en), 1);
        check("bs5_addr", int'(wr_addr), 4);
        check("bs5_data", int'(wr_data), 'h020);
        check("bs5_cursor", int'(cursor), 4);
        tick();
        send(2'b10, 9'h000);
        check("nl_mid_cursor", int'(cursor), 16);
        tick();

        // Reset in the middle of a clear.
        send(2'b11, 9'h000);
        k = 0;
        while (!(wr_en === 1'b1 && wr_addr === 6'd10) && k < 40) begin
            tick();
            k++;
        end
        check("midclr_reach_10", int'(wr_addr), 10);
        #2;
        rst = 1'b1;
        #1;
        check("midclr_wr_en_async", int'(wr_en), 0);
        check("midclr_busy", int'(busy), 1);
        check("midclr_ready", int'(key_ready), 0);
        check("midclr_cursor", int'(cursor), 0);
        tick();
        tick();
        rst = 1'b0;
        rel = cyc;
        wlog.delete();
        wait_ready(60);
        check_clear(rel + 1);
        check("midclr_total", wlog.size(), 32);
        check("midclr_final_cursor", int'(cursor), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
